// File: rtl/uart_tx_moore_fsm.sv
// ----------------------------------------------------------------------------
// uart_tx_moore_fsm
//
// Moore UART transmitter running directly on the baud clock (one clock = one
// bit time). A nonzero byte on bus_in while idle is captured and sent as an
// 8N1 frame: start bit, 8 data bits LSB first, stop bit. 0x00 means
// "no request" and cannot be sent.
//
// Ports:
//   clk_baud    in   1  baud clock, all state changes on rising edge
//   rst         in   1  asynchronous active-high reset
//   bus_in      in   8  byte to send; nonzero doubles as send request
//   serial_out  out  1  serial TX line, idles high
//
// State  | meaning
// -------+--------------------------------------------------
// IDLE   | line high, sampling bus_in for a nonzero byte
// START  | driving the start bit (0)
// DATA   | driving shift_q[0], shifting right each bit time
// STOP   | driving the stop bit (1), then back to IDLE
// ----------------------------------------------------------------------------
module uart_tx_moore_fsm (
    input  logic       clk_baud,
    input  logic       rst,
    input  logic [7:0] bus_in,
    output logic       serial_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       out_q, out_d;

    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            out_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        out_d     = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus_in != 8'h00) begin
                    shift_d   = bus_in;
                    bit_cnt_d = 3'd0;
                    state_d   = START;
                end
            end
            START: begin
                bit_cnt_d = 3'd0;
                state_d   = DATA;
            end
            DATA: begin
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level is decoded from the next state and registered, so
        // serial_out comes straight off a flop and cannot glitch mid-bit.
        case (state_d)
            IDLE:    out_d = 1'b1;
            START:   out_d = 1'b0;
            DATA:    out_d = shift_d[0];
            STOP:    out_d = 1'b1;
            default: out_d = 1'b1;
        endcase
    end

    assign serial_out = out_q;

endmodule

// File: tb/tb_uart_tx_moore_fsm.sv
module tb_uart_tx_moore_fsm;

    logic       clk_baud = 1'b0;
    logic       rst;
    logic [7:0] bus_in;
    logic       serial_out;

    int checks = 0;
    int errors = 0;
    int mon_idx = 0;
    logic exp_q[$];
    logic exp_bit;

    // Hand-computed frames: index 0 = start, 1..8 = d0..d7, 9 = stop.
    logic [0:9] frame_99 = 10'b0_10011001_1;
    logic [0:9] frame_62 = 10'b0_01000110_1;
    logic [0:9] frame_a5 = 10'b0_10100101_1;

    uart_tx_moore_fsm dut (
        .clk_baud   (clk_baud),
        .rst        (rst),
        .bus_in     (bus_in),
        .serial_out (serial_out)
    );

    always #5 clk_baud = ~clk_baud;

    // Monitor: one expected line level per rising edge, popped 1 ns after it.
    initial begin
        forever begin
            @(posedge clk_baud);
            #1;
            if (exp_q.size() > 0) begin
                exp_bit = exp_q.pop_front();
                checks++;
                if (serial_out !== exp_bit) begin
                    errors++;
                    $display("FAIL line[%0d] got %b want %b", mon_idx, serial_out, exp_bit);
                end
                mon_idx++;
            end
        end
    end

    // Drive bus_in for the next edge and queue the line level expected after it.
    task automatic slot(input logic [7:0] b, input logic e);
        @(negedge clk_baud);
        bus_in = b;
        exp_q.push_back(e);
    endtask

    // Ten frame slots plus one idle slot. bus_in = b for the first 'hold'
    // slots, 'noise' for the rest of the frame, 'tail' on the idle slot.
    task automatic frame(input logic [7:0] b, input logic [0:9] f, input int hold,
                         input logic [7:0] noise, input logic [7:0] tail);
        for (int i = 0; i < 10; i++) begin
            slot((i < hold) ? b : noise, f[i]);
        end
        slot((hold > 10) ? b : tail, 1'b1);
    endtask

    task automatic direct(input string name, input logic want);
        checks++;
        if (serial_out !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, serial_out, want);
        end
    endtask

    initial begin
        rst    = 1'b1;
        bus_in = 8'h00;
        #1;
        direct("reset_line", 1'b1);

        // A request while reset is held must not be captured.
        bus_in = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_baud);
            #1;
            direct("rst_held_no_capture", 1'b1);
        end
        @(negedge clk_baud);
        bus_in = 8'h00;
        rst    = 1'b0;

        for (int i = 0; i < 20; i++) slot(8'h00, 1'b1);

        // Single frame, then the next byte at the earliest legal edge (E11).
        frame(8'h99, frame_99, 1, 8'h00, 8'h00);
        frame(8'h62, frame_62, 1, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) slot(8'h00, 1'b1);

        // Request held over the start bit, then garbage mid-frame: ignored.
        frame(8'h99, frame_99, 2, 8'h33, 8'h00);
        for (int i = 0; i < 2; i++) slot(8'h00, 1'b1);

        // Held request: back-to-back frames every 11 cycles.
        for (int k = 0; k < 3; k++) frame(8'ha5, frame_a5, 11, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) slot(8'h00, 1'b1);

        // Reset in the middle of DATA (0xC3: d0=1, d1=1, d2=0).
        slot(8'hc3, 1'b0);
        slot(8'h00, 1'b1);
        slot(8'h00, 1'b1);
        slot(8'h00, 1'b0);
        @(negedge clk_baud);
        #2;
        rst = 1'b1;
        #1;
        direct("rst_mid_immediate", 1'b1);
        @(posedge clk_baud);
        #1;
        direct("rst_mid_held", 1'b1);
        @(negedge clk_baud);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) slot(8'h00, 1'b1);

        // Fresh frame after reset: aborted frame is not resumed.
        frame(8'h62, frame_62, 1, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) slot(8'h00, 1'b1);

        @(posedge clk_baud);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained got %0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
